bus_access_sequencer: RTL

Sequences and shares the two-bit region decoder between two bus requesters. Arbitrates round-robin between `req0`/`req1`, captures the winner's `addr[31:30]`, and drives a SETUP → ACCESS → HOLD access cycle. The region chip enable (`ce0`, `ce1`, `cs`) is asserted for a per-region number of wait states, and the block returns a one-cycle `done` pulse to the served requester. It sits between the requesters and the memory/peripheral chip-enable pins.

---
 rtl/bus_seq_pkg.sv | 26 ++
 rtl/region_decode.sv | 34 +++
 rtl/bus_access_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bus_seq_pkg.sv
// Shared types and constants for the bus access sequencer.
package bus_seq_pkg;

    // Access cycle phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Region selects taken from addr[31:30].
    localparam logic [1:0] REG_CE0 = 2'b10;
    localparam logic [1:0] REG_CE1 = 2'b11;
    // Any region with bit 1 clear selects cs; bit 0 is a don't-care.
    localparam logic [1:0] REG_CS  = 2'b00;

    // Shared setup / wait-state down-counter.
    typedef logic [3:0] cnt_t;

    // True when the region maps to the cs chip enable.
    function automatic logic is_cs_region(input logic [1:0] region);
        return (region[1] == REG_CS[1]);
    endfunction

endpackage

// File: rtl/region_decode.sv
// Maps the captured region to a one-hot chip enable and its wait-state count.
module region_decode
    import bus_seq_pkg::*;
#(
    parameter int WS_CE0 = 2,
    parameter int WS_CE1 = 2,
    parameter int WS_CS  = 0
) (
    input  logic [1:0] addr,
    input  logic       en,
    output logic       ce0,
    output logic       ce1,
    output logic       cs,
    output cnt_t       ws
);

    // Wait-state select is always valid; enables only assert when en is high.
    always_comb begin
        ce0 = 1'b0;
        ce1 = 1'b0;
        cs  = 1'b0;
        ws  = cnt_t'(WS_CS);
        if (addr == REG_CE0) begin
            ce0 = en;
            ws  = cnt_t'(WS_CE0);
        end else if (addr == REG_CE1) begin
            ce1 = en;
            ws  = cnt_t'(WS_CE1);
        end else if (is_cs_region(addr)) begin
            cs  = en;
        end
    end

endmodule

// File: rtl/bus_access_sequencer.sv
// Round-robin shared region decoder with SETUP/ACCESS/HOLD access cycles.
module bus_access_sequencer
    import bus_seq_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int WS_CE0    = 2,
    parameter int WS_CE1    = 2,
    parameter int WS_CS     = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [31:30] addr0,
    input  logic [31:30] addr1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         bus_en,
    output logic [31:30] bus_addr,
    output logic         ce0,
    output logic         ce1,
    output logic         cs,
    output logic         busy
);

    state_t       state, state_nx;
    cnt_t         cnt, cnt_nx;
    logic         last, last_nx;
    logic         win;
    logic [31:30] addr_nx;
    logic         gnt0_nx, gnt1_nx, done0_nx, done1_nx, bus_en_nx, busy_nx;
    logic         dec_en, dec_ce0, dec_ce1, dec_cs;
    cnt_t         dec_ws;

    // Decoder looks at the captured address; enable selects cycles that
    // will be ACCESS after the next edge, so the chip enables are registered.
    region_decode #(
        .WS_CE0 (WS_CE0),
        .WS_CE1 (WS_CE1),
        .WS_CS  (WS_CS)
    ) u_decode (
        .addr (bus_addr),
        .en   (dec_en),
        .ce0  (dec_ce0),
        .ce1  (dec_ce1),
        .cs   (dec_cs),
        .ws   (dec_ws)
    );

    // Next-state, arbitration and next output values.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        last_nx   = last;
        win       = 1'b0;
        addr_nx   = bus_addr;
        gnt0_nx   = gnt0;
        gnt1_nx   = gnt1;
        bus_en_nx = bus_en;
        done0_nx  = 1'b0;
        done1_nx  = 1'b0;
        dec_en    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // Under contention the requester not served last wins.
                    win       = (req0 && req1) ? ~last : req1;
                    state_nx  = SETUP;
                    cnt_nx    = cnt_t'(SETUP_CYC - 1);
                    last_nx   = win;
                    addr_nx   = win ? addr1 : addr0;
                    gnt0_nx   = ~win;
                    gnt1_nx   = win;
                    bus_en_nx = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nx = ACCESS;
                    cnt_nx   = dec_ws;
                    dec_en   = 1'b1;
                end else begin
                    cnt_nx   = cnt - 1'b1;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nx = HOLD;
                    done0_nx = gnt0;
                    done1_nx = gnt1;
                end else begin
                    cnt_nx   = cnt - 1'b1;
                    dec_en   = 1'b1;
                end
            end
            HOLD: begin
                state_nx  = IDLE;
                gnt0_nx   = 1'b0;
                gnt1_nx   = 1'b0;
                bus_en_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            bus_addr <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            bus_en   <= 1'b0;
            ce0      <= 1'b0;
            ce1      <= 1'b0;
            cs       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            last     <= last_nx;
            bus_addr <= addr_nx;
            gnt0     <= gnt0_nx;
            gnt1     <= gnt1_nx;
            done0    <= done0_nx;
            done1    <= done1_nx;
            bus_en   <= bus_en_nx;
            ce0      <= dec_ce0;
            ce1      <= dec_ce1;
            cs       <= dec_cs;
            busy     <= busy_nx;
        end
    end

endmodule
